// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide.
// Holds the architectural HI/LO registers and accepts MTHI/MTLO writes.
module mult_div_unit #(
    parameter int XLEN = 32,
    parameter int CW   = 6
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            abort,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_a_q, neg_a_d;
    logic              dz_q, dz_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [2*XLEN-1:0] prod_q, prod_d;

    logic              op_signed;
    logic              sgn_a, sgn_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] mul_step, div_step, prod_fix;
    logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix;

    // Operand conditioning: magnitudes and signs for signed ops.
    always_comb begin
        op_signed = ~op[0];
        sgn_a     = op_signed & rs_data[XLEN-1];
        sgn_b     = op_signed & rt_data[XLEN-1];
        abs_a     = sgn_a ? -rs_data : rs_data;
        abs_b     = sgn_b ? -rt_data : rt_data;
    end

    // One iteration of each algorithm plus the final sign fix-up.
    // Multiply: upper half accumulates, multiplier shifts out of the low end.
    // Divide: upper half is the remainder, quotient bits shift in at bit 0.
    always_comb begin
        add_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]}
                 + (prod_q[0] ? {1'b0, b_q} : '0);
        mul_step = {add_sum, prod_q[XLEN-1:1]};
        rem_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        diff     = rem_sh - {1'b0, b_q};
        div_step = {diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0],
                    prod_q[XLEN-2:0], ~diff[XLEN]};
        prod_fix = neg_res_q ? -prod_q : prod_q;
        quo      = prod_q[XLEN-1:0];
        rem      = prod_q[2*XLEN-1:XLEN];
        // A zero divisor yields an all-ones quotient regardless of sign.
        quo_fix  = (neg_res_q && !dz_q) ? -quo : quo;
        rem_fix  = neg_a_q ? -rem : rem;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        dz_d      = dz_q;
        b_d       = b_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !abort) begin
                    is_div_d  = op[1];
                    neg_res_d = sgn_a ^ sgn_b;
                    neg_a_d   = sgn_a;
                    dz_d      = (rt_data == '0);
                    cnt_d     = CW'(XLEN - 1);
                    if (op[1]) begin
                        b_d    = abs_b;
                        prod_d = {{XLEN{1'b0}}, abs_a};
                    end else begin
                        b_d    = abs_a;
                        prod_d = {{XLEN{1'b0}}, abs_b};
                    end
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    prod_d = is_div_q ? div_step : mul_step;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == '0) state_d = FIX;
                end
            end
            FIX: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and register file for the unit.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            dz_q      <= 1'b0;
            b_q       <= '0;
            prod_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            dz_q      <= dz_d;
            b_q       <= b_d;
            prod_q    <= prod_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst_b;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        abort;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;
    int done_edge;
    int busy_cyc;
    int seen;

    mult_div_unit #(.XLEN(32), .CW(6)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .abort   (abort),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an op at the next edge (E0) and runs until busy drops.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        tick();
        start     = 1'b0;
        busy_cyc  = busy ? 1 : 0;
        done_edge = -1;
        for (int n = 1; n <= 50 && busy; n++) begin
            tick();
            if (done) done_edge = n;
            if (busy) busy_cyc++;
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_b   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = '0;
        rt_data = '0;
        abort   = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        repeat (2) tick();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        rst_b = 1'b1;
        tick();

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("mult_done_edge", done_edge, 32'd33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("multu_busy_cyc", busy_cyc, 32'd34);
        chk("multu_done_edge", done_edge, 32'd33);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
        chk("mult_negneg_hi", hi, 32'h0);
        chk("mult_negneg_lo", lo, 32'd15);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd100, 32'd7);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        run_op(OP_DIVU, 32'h0000_0007, 32'h0);
        chk("divu0_done_edge", done_edge, 32'd33);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'h0000_0007);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'hFFFF_FFF9);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0);

        // Asynchronous reset in the middle of RUN.
        run_op(OP_MULTU, 32'd9, 32'd9);
        op      = OP_MULTU;
        rs_data = 32'h1234_5678;
        rt_data = 32'h0000_0010;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst_b = 1'b0;
        #1;
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        tick();
        rst_b = 1'b1;
        tick();
        chk("arst_idle_busy", {31'b0, busy}, 32'h0);
        chk("arst_idle_done", {31'b0, done}, 32'h0);

        // Abort together with start in IDLE: nothing starts.
        op      = OP_MULTU;
        rs_data = 32'd3;
        rt_data = 32'd5;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_idle_busy", {31'b0, busy}, 32'h0);

        // MTHI preload, then abort an in-flight MULTU.
        hi_we = 1'b1;
        wdata = 32'h1111_1111;
        tick();
        hi_we = 1'b0;
        chk("mthi", hi, 32'h1111_1111);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) seen = 1;
            tick();
        end
        chk("abort_no_done", seen, 32'd0);
        chk("abort_hi", hi, 32'h1111_1111);
        chk("abort_lo", lo, 32'h0);

        // Second start and MTLO while busy are ignored.
        op      = OP_MULTU;
        rs_data = 32'd3;
        rt_data = 32'd5;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op      = OP_DIVU;
        rs_data = 32'd100;
        rt_data = 32'd7;
        start   = 1'b1;
        lo_we   = 1'b1;
        wdata   = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        lo_we = 1'b0;
        chk("busy_mtlo_ign", lo, 32'h0);
        seen = 0;
        for (int n = 0; n < 40 && !done; n++) tick();
        if (done) seen = 1;
        chk("ign_done_seen", seen, 32'd1);
        chk("ign_lo", lo, 32'd15);
        chk("ign_hi", hi, 32'h0);
        tick();
        chk("ign_idle", {31'b0, busy}, 32'h0);

        // MTLO in IDLE.
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        lo_we = 1'b0;
        chk("mtlo_idle", lo, 32'hDEAD_BEEF);
        chk("mtlo_hi_kept", hi, 32'h0);

        // MTHI alongside start: write lands, result then overwrites it.
        hi_we   = 1'b1;
        wdata   = 32'hCAFE_F00D;
        op      = OP_DIVU;
        rs_data = 32'd100;
        rt_data = 32'd7;
        start   = 1'b1;
        tick();
        hi_we = 1'b0;
        start = 1'b0;
        chk("mthi_start_hi", hi, 32'hCAFE_F00D);
        chk("mthi_start_busy", {31'b0, busy}, 32'h1);
        for (int n = 0; n < 40 && busy; n++) tick();
        chk("mthi_start_res_hi", hi, 32'd2);
        chk("mthi_start_res_lo", lo, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS core.
- Sits directly downstream of the register file: consumes the rs_data/rt_data read operands for MULT/MULTU/DIV/DIVU and holds the architectural HI/LO registers.
- MFHI/MFLO results return to the register file write port through the normal writeback path.
- MTHI/MTLO writes arrive on a dedicated write port.

Parameters:
- XLEN, 32, operand, HI and LO width.
- CW, 6, iteration counter width; must satisfy 2^CW > XLEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_b  input  1  asynchronous active-low reset.
- start  input  1  request to begin the operation selected by op; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  XLEN  operand A (multiplicand / dividend).
- rt_data  input  XLEN  operand B (multiplier / divisor).
- abort  input  1  pipeline flush; cancels an in-flight operation.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  XLEN  MTHI/MTLO data.
- busy  output  1  operation in flight; the pipeline stalls MFHI/MFLO and new mult/div while high.
- done  output  1  one-cycle pulse: new HI/LO visible this cycle.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Reset (rst_b=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and internal registers cleared. Applies at any point, including mid-operation, and discards the operation.
- States: IDLE, RUN, FIX, DONE. busy = (state != IDLE). done = (state == DONE).
- IDLE, start=1 at edge E0:
  - Latch op.
  - Signed ops latch |rs_data| and |rt_data| plus sign bits. Unsigned ops latch raw values.
  - counter=XLEN-1; go to RUN.
- RUN: one iteration per edge, edges E1..E32 (XLEN iterations). After the iteration with counter==0, go to FIX.
  - Multiply: shift-add over a 2*XLEN product register.
  - Divide: restoring, one quotient bit per edge, using XLEN+1-bit subtraction.
- FIX, edge E33: apply sign correction, write hi/lo, go to DONE.
  - Multiply: product negated if signs differ; hi=upper XLEN bits, lo=lower XLEN bits.
  - Divide: quotient negated if signs differ; remainder takes the dividend's sign; lo=quotient, hi=remainder.
- DONE: done=1 for exactly one cycle; next edge (E34) returns to IDLE. Total start-to-done latency is 33 edges; busy is high for 34 cycles.
- Divide by zero (rt_data==0): same latency, no exception. Result is lo=all ones, hi=rs_data, regardless of signedness.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0. Wraps, no trap.
- Widths: all arithmetic modulo 2^XLEN on hi/lo; the product register is 2*XLEN bits wide.
- start while busy: ignored, no queueing. The controller must not issue it.
- abort while busy: next edge goes to IDLE; hi/lo unchanged; done is not pulsed.
- abort in IDLE together with start: abort wins, no operation starts.
- abort with no operation in flight: no effect.
- hi_we/lo_we:
  - In IDLE, the write takes effect at the edge.
  - If start is also asserted that cycle, the write is applied and the operation still starts; the later result overwrites HI/LO.
  - While busy, writes are ignored.
- hi and lo are registered outputs with no combinational path from any input.

Test Plan:
- Reset: assert rst_b=0 mid-RUN (cycle 10 after start) -> hi=0, lo=0, busy=0 immediately; after release, idle with done=0.
- Multiply: MULT rs=0xFFFFFFFF, rt=0x00000002 -> done at E33, hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE; busy high exactly 34 cycles.
- Signed divide: DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=7 -> lo=14, hi=2.
- Divide by zero: DIVU rs=0x00000007, rt=0 -> lo=0xFFFFFFFF, hi=0x00000007 at E33. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Abort: preload hi=0x11111111 via MTHI; start MULTU 3*5, assert abort at cycle 12 -> busy=0 next cycle, no done pulse, hi=0x11111111 unchanged.
- Ignored inputs: second start and lo_we with wdata=0xDEADBEEF issued while busy -> ignored; first result 3*5 gives lo=15, hi=0. Afterwards, MTLO in IDLE -> lo=0xDEADBEEF next cycle.
